pong_sound_seq: RTL and testbench

Event-driven sound sequencer for the Pong game: converts single-cycle `hit` and `game_over` event pulses from the game FSM into timed square-wave tone sequences on one speaker pin. It sits directly downstream of the game-control FSM, replacing ad-hoc `play` levels with a self-timed player. A single hit produces one short beep. Game over produces a three-note descending phrase.

---
 rtl/pong_sound_seq_pkg.sv | 40 ++++
 rtl/pong_sound_seq_if.sv | 14 +
 rtl/pong_sound_seq_tone_gen.sv | 34 +++
 rtl/pong_sound_seq.sv | 152 +++++++++++++++
 tb/tb_pong_sound_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pong_sound_seq_pkg.sv
// Shared types and constants for the Pong sound sequencer: FSM states,
// sound-id encodings, default tone/duration constants and counter widths.
package pong_sound_pkg;

  localparam int TONE_W = 18;
  localparam int DUR_W  = 25;

  localparam int HALF_HIT_DEF = 56818;
  localparam int HALF_O1_DEF  = 113636;
  localparam int HALF_O2_DEF  = 151515;
  localparam int HALF_O3_DEF  = 227272;
  localparam int DUR_HIT_DEF  = 5000000;
  localparam int DUR_NOTE_DEF = 20000000;
  localparam int DUR_GAP_DEF  = 2000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIT,
    ST_O1,
    ST_O2,
    ST_O3,
    ST_G1,
    ST_G2
  } state_e;

  typedef enum logic [1:0] {
    SND_NONE = 2'd0,
    SND_HIT  = 2'd1,
    SND_OVER = 2'd2
  } snd_id_e;

  function automatic snd_id_e snd_class(input state_e s);
    case (s)
      ST_IDLE: return SND_NONE;
      ST_HIT:  return SND_HIT;
      default: return SND_OVER;
    endcase
  endfunction

endpackage

// File: rtl/pong_sound_seq_if.sv
// Event/status bundle between the game-control FSM (master) and the
// sound sequencer (slave).
interface pong_sound_seq_if;
  logic       hit_evt;
  logic       over_evt;
  logic       speaker;
  logic       busy;
  logic [1:0] snd_id;

  modport master (output hit_evt, output over_evt,
                  input  speaker, input busy, input snd_id);
  modport slave  (input  hit_evt, input over_evt,
                  output speaker, output busy, output snd_id);
endinterface

// File: rtl/pong_sound_seq_tone_gen.sv
// Square-wave tone generator: toggles the speaker flop every half_m1_i+1
// cycles while enabled; restart or disable forces phase and output to zero.
module tone_gen
  import pong_sound_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart_i,
  input  logic              enable_i,
  input  logic [TONE_W-1:0] half_m1_i,
  output logic              speaker_o
);

  logic [TONE_W-1:0] tone_cnt_q;
  logic              spk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      spk_q      <= 1'b0;
    end else if (restart_i || !enable_i) begin
      tone_cnt_q <= '0;
      spk_q      <= 1'b0;
    end else if (tone_cnt_q == half_m1_i) begin
      tone_cnt_q <= '0;
      spk_q      <= ~spk_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + 1'b1;
    end
  end

  assign speaker_o = spk_q;

endmodule

// File: rtl/pong_sound_seq.sv
// Event-driven Pong sound sequencer: hit beep and three-note game-over phrase.
// Define PONG_SOUND_GAP_EN to insert silent gaps between game-over notes.
module pong_sound_seq
  import pong_sound_pkg::*;
#(
  parameter int HALF_HIT = HALF_HIT_DEF,
  parameter int HALF_O1  = HALF_O1_DEF,
  parameter int HALF_O2  = HALF_O2_DEF,
  parameter int HALF_O3  = HALF_O3_DEF,
  parameter int DUR_HIT  = DUR_HIT_DEF,
  parameter int DUR_NOTE = DUR_NOTE_DEF,
  parameter int DUR_GAP  = DUR_GAP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  pong_sound_seq_if.slave  snd
);

  if (HALF_HIT < 1 || HALF_HIT > (1 << TONE_W) ||
      HALF_O1  < 1 || HALF_O1  > (1 << TONE_W) ||
      HALF_O2  < 1 || HALF_O2  > (1 << TONE_W) ||
      HALF_O3  < 1 || HALF_O3  > (1 << TONE_W) ||
      DUR_HIT  < 1 || DUR_HIT  > (1 << DUR_W)  ||
      DUR_NOTE < 1 || DUR_NOTE > (1 << DUR_W)  ||
      DUR_GAP  < 1 || DUR_GAP  > (1 << DUR_W)) begin : g_param_err
    $error("pong_sound_seq: half-period or duration parameter out of counter range");
  end

  localparam logic [TONE_W-1:0] HM1_HIT  = TONE_W'(HALF_HIT - 1);
  localparam logic [TONE_W-1:0] HM1_O1   = TONE_W'(HALF_O1 - 1);
  localparam logic [TONE_W-1:0] HM1_O2   = TONE_W'(HALF_O2 - 1);
  localparam logic [TONE_W-1:0] HM1_O3   = TONE_W'(HALF_O3 - 1);
  localparam logic [DUR_W-1:0]  DM1_HIT  = DUR_W'(DUR_HIT - 1);
  localparam logic [DUR_W-1:0]  DM1_NOTE = DUR_W'(DUR_NOTE - 1);
`ifdef PONG_SOUND_GAP_EN
  localparam logic [DUR_W-1:0]  DM1_GAP  = DUR_W'(DUR_GAP - 1);
`endif

  // Assert asynchronously, release two clocks after reset deasserts.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic              hit_q, over_q;
  state_e            state_q, state_d;
  logic [DUR_W-1:0]  dur_q, dur_d, dur_m1;
  logic              expire;
  logic              restart_d;
  logic              tone_en_d;
  logic [TONE_W-1:0] half_m1_d;
  logic              busy_q;
  snd_id_e           snd_id_q;
  logic              spk;

  always_comb begin
    dur_m1 = '0;
    case (state_q)
      ST_HIT:  dur_m1 = DM1_HIT;
      ST_O1, ST_O2, ST_O3: dur_m1 = DM1_NOTE;
`ifdef PONG_SOUND_GAP_EN
      ST_G1, ST_G2: dur_m1 = DM1_GAP;
`endif
      default: dur_m1 = '0;
    endcase
  end

  assign expire = (dur_q == dur_m1);

  // Events outrank a coinciding expiry; over_evt outranks hit_evt everywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (over_q)     state_d = ST_O1;
        else if (hit_q) state_d = ST_HIT;
      end
      ST_HIT: begin
        if (over_q)      state_d = ST_O1;
        else if (hit_q)  state_d = ST_HIT;
        else if (expire) state_d = ST_IDLE;
      end
`ifdef PONG_SOUND_GAP_EN
      ST_O1: if (over_q) state_d = ST_O1; else if (expire) state_d = ST_G1;
      ST_G1: if (over_q) state_d = ST_O1; else if (expire) state_d = ST_O2;
      ST_O2: if (over_q) state_d = ST_O1; else if (expire) state_d = ST_G2;
      ST_G2: if (over_q) state_d = ST_O1; else if (expire) state_d = ST_O3;
`else
      ST_O1: if (over_q) state_d = ST_O1; else if (expire) state_d = ST_O2;
      ST_O2: if (over_q) state_d = ST_O1; else if (expire) state_d = ST_O3;
`endif
      ST_O3: if (over_q) state_d = ST_O1; else if (expire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign restart_d = (state_d != state_q) || over_q || (hit_q && state_q == ST_HIT);

  always_comb begin
    tone_en_d = 1'b1;
    half_m1_d = HM1_HIT;
    case (state_d)
      ST_HIT: half_m1_d = HM1_HIT;
      ST_O1:  half_m1_d = HM1_O1;
      ST_O2:  half_m1_d = HM1_O2;
      ST_O3:  half_m1_d = HM1_O3;
      default: begin
        tone_en_d = 1'b0;
        half_m1_d = '0;
      end
    endcase
  end

  assign dur_d = (restart_d || state_d == ST_IDLE) ? '0 : dur_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q    <= 1'b0;
      over_q   <= 1'b0;
      state_q  <= ST_IDLE;
      dur_q    <= '0;
      busy_q   <= 1'b0;
      snd_id_q <= SND_NONE;
    end else begin
      hit_q    <= snd.hit_evt;
      over_q   <= snd.over_evt;
      state_q  <= state_d;
      dur_q    <= dur_d;
      busy_q   <= (state_d != ST_IDLE);
      snd_id_q <= snd_class(state_d);
    end
  end

  tone_gen u_tone_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart_d),
    .enable_i  (tone_en_d),
    .half_m1_i (half_m1_d),
    .speaker_o (spk)
  );

  assign snd.speaker = spk;
  assign snd.busy    = busy_q;
  assign snd.snd_id  = snd_id_q;

endmodule

// File: tb/tb_pong_sound_seq.sv
// Directed bench for pong_sound_seq with small tone/duration parameters.
module tb_pong_sound_seq;

  localparam int LEN_HIT = 24;
`ifdef PONG_SOUND_GAP_EN
  localparam int LEN_OVER = 136;
  localparam int NSEG = 5;
`else
  localparam int LEN_OVER = 120;
  localparam int NSEG = 3;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pong_sound_seq_if bus ();

  pong_sound_seq #(
    .HALF_HIT(3), .HALF_O1(4), .HALF_O2(5), .HALF_O3(6),
    .DUR_HIT(24), .DUR_NOTE(40), .DUR_GAP(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .snd   (bus)
  );

  typedef struct {
    string      nm;
    logic       h;
    logic       o;
    logic [1:0] snd;
    int         len;
  } vec_t;

  vec_t vecs[4];

  // Game-over note layout: segment lengths and half-periods (0 = silent gap).
  function automatic logic over_spk(input int k);
    int lens[NSEG];
    int halfs[NSEG];
    int rem;
`ifdef PONG_SOUND_GAP_EN
    lens  = '{40, 8, 40, 8, 40};
    halfs = '{4, 0, 5, 0, 6};
`else
    lens  = '{40, 40, 40};
    halfs = '{4, 5, 6};
`endif
    rem = k;
    for (int i = 0; i < NSEG; i++) begin
      if (rem < lens[i]) begin
        if (halfs[i] == 0) return 1'b0;
        return ((rem / halfs[i]) % 2) == 1;
      end
      rem -= lens[i];
    end
    return 1'b0;
  endfunction

  // Expected {busy, snd_id, speaker} k cycles after sequence entry.
  function automatic logic [3:0] exp_out(input logic [1:0] snd, input int len, input int k);
    logic sp;
    if (k < 0 || k >= len) return 4'b0000;
    if (snd == 2'd1) sp = ((k / 3) % 2) == 1;
    else             sp = over_spk(k);
    return {1'b1, snd, sp};
  endfunction

  task automatic chk(input string nm, input int c, input logic [3:0] exp);
    logic [3:0] act;
    act = {bus.busy, bus.snd_id, bus.speaker};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got busy,snd,spk=%b want=%b", nm, c, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Drive inputs for one cycle just after the rising edge, then sample at the falling edge.
  task automatic cyc(input logic h, input logic o);
    @(posedge clk);
    #1;
    bus.hit_evt  = h;
    bus.over_evt = o;
    @(negedge clk);
  endtask

  task automatic run_single(input string nm, input logic h, input logic o,
                            input logic [1:0] snd, input int len);
    int busy_cnt;
    busy_cnt = 0;
    for (int c = 0; c < len + 6; c++) begin
      cyc((c == 0) ? h : 1'b0, (c == 0) ? o : 1'b0);
      if (bus.busy === 1'b1) busy_cnt++;
      chk(nm, c, exp_out(snd, len, c - 2));
    end
    chk_int({nm, "_busy_len"}, busy_cnt, len);
  endtask

  initial begin
    vecs[0] = '{nm: "hit",       h: 1'b1, o: 1'b0, snd: 2'd1, len: LEN_HIT};
    vecs[1] = '{nm: "over",      h: 1'b0, o: 1'b1, snd: 2'd2, len: LEN_OVER};
    vecs[2] = '{nm: "both",      h: 1'b1, o: 1'b1, snd: 2'd2, len: LEN_OVER};
    vecs[3] = '{nm: "hit_again", h: 1'b1, o: 1'b0, snd: 2'd1, len: LEN_HIT};

    bus.hit_evt  = 1'b0;
    bus.over_evt = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_state", -1, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 1'b0);
      chk("post_reset_idle", c, 4'b0000);
    end

    for (int v = 0; v < 4; v++)
      run_single(vecs[v].nm, vecs[v].h, vecs[v].o, vecs[v].snd, vecs[v].len);

    // Retrigger: second hit 10 cycles after the first restarts duration and phase.
    begin
      int busy_cnt;
      busy_cnt = 0;
      for (int c = 0; c < 42; c++) begin
        cyc(c == 0 || c == 10, 1'b0);
        if (bus.busy === 1'b1) busy_cnt++;
        if (c < 12) chk("retrig", c, exp_out(2'd1, LEN_HIT, c - 2));
        else        chk("retrig", c, exp_out(2'd1, LEN_HIT, c - 12));
      end
      chk_int("retrig_busy_len", busy_cnt, 34);
    end

    // hit_evt during O2 leaves the phrase untouched.
    begin
      int busy_cnt;
      busy_cnt = 0;
      for (int c = 0; c < LEN_OVER + 6; c++) begin
        cyc(c == 60, c == 0);
        if (bus.busy === 1'b1) busy_cnt++;
        chk("hit_in_o2", c, exp_out(2'd2, LEN_OVER, c - 2));
      end
      chk_int("hit_in_o2_busy_len", busy_cnt, LEN_OVER);
    end

    // over_evt during a beep switches straight to O1.
    for (int c = 0; c < LEN_OVER + 18; c++) begin
      cyc(c == 0, c == 10);
      if (c < 12) chk("over_in_hit", c, exp_out(2'd1, LEN_HIT, c - 2));
      else        chk("over_in_hit", c, exp_out(2'd2, LEN_OVER, c - 12));
    end

    // Reset asserted during O2 clears outputs without waiting for a clock.
    for (int c = 0; c <= 60; c++) begin
      cyc(1'b0, c == 0);
      chk("pre_reset", c, exp_out(2'd2, LEN_OVER, c - 2));
    end
    #2 reset = 1'b0;
    #1 chk("async_reset", 60, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0);
      chk("in_reset", c, 4'b0000);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 1'b0);
      chk("release_idle", c, 4'b0000);
    end
    run_single("hit_after_reset", 1'b1, 1'b0, 2'd1, LEN_HIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
